decoder_n_seq: RTL
==================

# decoder_n_seq

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready select port and an auto-scan mode. In DECODE mode it latches a select and holds the matching one-hot output. In SCAN mode it steps the active output through all 2^N lines with a programmable dwell. It drives select/strobe lines for downstream blocks that need glitch-free, registered enables rather than combinational decode.

## Interface
- SEL_W, default 3: select width. OUT_W = 2**SEL_W is a derived localparam, not overridable.
- DWELL_W, default 8: dwell counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. Single clock domain.
- en  in  1  block enable. Low forces IDLE.
- mode  in  1  0 = DECODE, 1 = SCAN. Sampled only on an accepted handshake.
- sel_valid  in  1  select request.
- sel_ready  out  1  select accept.
- sel  in  SEL_W  requested output index. In SCAN mode, the start index.
- dwell  in  DWELL_W  SCAN only: cycles per step minus 1. Sampled on handshake.
- y  out  OUT_W  registered one-hot output, or all-zero.
- y_valid  out  1  high when y is one-hot (state ≠ IDLE).
- cur_sel  out  SEL_W  index of the active bit in y.
- wrap  out  1  one-cycle pulse when SCAN steps from OUT_W-1 to 0.

## Operation
States:
- **IDLE**
  - y=0, y_valid=0.
  - Accept (sel_valid & sel_ready) with mode=0 → HOLD. With mode=1 → SCAN.
- **HOLD**
  - y = 1<<cur_sel, held indefinitely.
  - sel_ready=1, so a new accept updates y and cur_sel. Back-to-back accepts change y every cycle.
  - An accept with mode=1 → SCAN.
- **SCAN**
  - sel_ready=0; sel_valid is ignored.
  - On entry: cur_sel=sel, the counter is loaded with dwell, and dwell is latched into dwell_q.
  - The counter decrements each cycle. On counter==0: cur_sel+1 (modulo OUT_W) and counter=dwell_q.
  - dwell=0 steps every cycle.
  - The mode input is ignored after entry. The only exit is en low.

Common rules:
- sel_ready = rst_n & en & (state ≠ SCAN). It is combinational from state and en.
- en low in any state → IDLE on the next edge, with y=0 and y_valid=0. en low has priority over a simultaneous accept, which is not taken (ready is low).
- y is always exactly one-hot or zero. There is never a multi-hot or transient value.
- wrap is asserted only in SCAN, in the cycle in which y moves from bit OUT_W-1 to bit 0.
- Reset values: state=IDLE, y=0, y_valid=0, cur_sel=0, wrap=0, counter=0, dwell_q=0. sel_ready=0 during reset.
- Reset asserted mid-operation clears everything immediately (asynchronously). No handshake is pending after release.

## Timing
- Latency: accept at edge k → y, y_valid and cur_sel updated after edge k, visible in cycle k+1.
- SCAN: the start bit is held for dwell+1 cycles, then each following bit for dwell_q+1 cycles.
- en deassert in cycle k → y=0 in cycle k+1.
- wrap is registered and coincident with the y change to bit 0.

## Configuration
- DECODER_SCAN_EN defined: SCAN state, dwell counter, dwell_q and wrap logic are present, as described above.
- DECODER_SCAN_EN undefined:
  - The mode and dwell ports remain but are ignored. Every accept behaves as mode=0.
  - wrap is tied to 0.
  - sel_ready = rst_n & en.
  - The SCAN state and counter are not synthesised.

## Structure
- Package decoder_pkg:
  - state enum: IDLE, HOLD, SCAN.
  - constants: MODE_DECODE=1'b0, MODE_SCAN=1'b1.
- Sub-module decoder_onehot: purely combinational SEL_W → OUT_W one-hot decode with an enable input. decoder_n_seq instantiates it and registers its output.

## Test plan
- Reset then en=1, accept sel=5, mode=0 (SEL_W=3) → next cycle y=8'b0010_0000, y_valid=1, cur_sel=5. y holds until the next accept.
- In HOLD, accept sel=1, 2, 7 on consecutive cycles → y=0x02, 0x04, 0x80 on the following cycles, with no zero or multi-hot cycle in between.
- Accept mode=1, sel=6, dwell=2 → y bit6 for 3 cycles, bit7 for 3 cycles, then bit0 with wrap=1 for exactly one cycle. sel_ready stays 0 throughout.
- SCAN with dwell=0: en deasserted mid-scan → y=0, y_valid=0 next cycle. sel_ready returns to 1 once en is high again.
- en=0 coincident with sel_valid=1 in IDLE → sel_ready=0, no accept, y stays 0. rst_n pulsed low mid-SCAN → y=0, cur_sel=0, wrap=0 immediately, without waiting for a clock edge.
- Build without DECODER_SCAN_EN: accept mode=1, sel=3 → HOLD with y=0x08. wrap is never asserted and sel_ready stays high.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : decoder_pkg
// Brief   : Shared state encoding and mode constants for the one-hot decoder.
// Revision: 1.0 - initial release
// ============================================================================
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_onehot.sv
`default_nettype none
// ============================================================================
// Module  : decoder_onehot
// Brief   : Combinational SEL_W -> 2**SEL_W one-hot decode with enable.
// Revision: 1.0 - initial release
// ============================================================================
module decoder_onehot #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] y
);

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign y[i] = en & (sel == SEL_W'(i));
    end

endmodule : decoder_onehot
`default_nettype wire

// File: rtl/decoder_n_seq.sv
`default_nettype none
// ============================================================================
// Module  : decoder_n_seq
// Brief   : Registered one-hot decoder with valid/ready select and auto-scan.
//           Scan mode is present only when DECODER_SCAN_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   y,
    output logic               y_valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_cur_sel;
    logic [SEL_W-1:0]   w_cur_sel_nxt;
    logic [OUT_W-1:0]   r_y;
    logic [OUT_W-1:0]   w_y_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic               w_accept;
    logic               w_mode_scan;
    logic               w_step;

    assign w_accept = sel_valid & sel_ready;

`ifdef DECODER_SCAN_EN
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell_q;

    assign w_mode_scan = (mode == MODE_SCAN);
    assign w_step      = (r_state == SCAN) && (r_cnt == '0);
    assign w_wrap_nxt  = en && w_step && (r_cur_sel == {SEL_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_dwell_q <= '0;
        end else if (w_accept && w_mode_scan) begin
            r_cnt     <= dwell;
            r_dwell_q <= dwell;
        end else if (en && r_state == SCAN) begin
            r_cnt     <= w_step ? r_dwell_q : r_cnt - DWELL_W'(1);
        end
    end
`else
    logic w_unused_ok;

    // Without scan support every accept decodes; mode and dwell are don't-care.
    assign w_mode_scan = 1'b0;
    assign w_step      = 1'b0;
    assign w_wrap_nxt  = 1'b0;
    assign w_unused_ok = ^{mode, dwell};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; en low wins over everything
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_accept) begin
                        w_state_nxt = w_mode_scan ? SCAN : HOLD;
                    end
                end
                SCAN:    w_state_nxt = SCAN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
`ifdef DECODER_SCAN_EN
        sel_ready = rst_n & en & (r_state != SCAN);
`else
        sel_ready = rst_n & en;
`endif
        y_valid   = (r_state != IDLE);
    end

    always_comb begin
        w_cur_sel_nxt = r_cur_sel;
        if (w_accept) begin
            w_cur_sel_nxt = sel;
        end else if (en && w_step) begin
            w_cur_sel_nxt = r_cur_sel + SEL_W'(1);
        end
    end

    // Decoding the next index keeps y a clean registered one-hot every cycle.
    decoder_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel (w_cur_sel_nxt),
        .en  (w_state_nxt != IDLE),
        .y   (w_y_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_sel <= '0;
            r_y       <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_cur_sel <= w_cur_sel_nxt;
            r_y       <= w_y_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    assign y       = r_y;
    assign cur_sel = r_cur_sel;
    assign wrap    = r_wrap;

endmodule : decoder_n_seq
`default_nettype wire
